// File: rtl/record_mode_if.sv
// Decoded key-hit bus from the hit decoder into the song capture engine.
// Every control line is a single-cycle pulse; the receiver never pushes back.
interface record_mode_if;
   logic       hit_valid;
   logic [2:0] hit_octave;
   logic [2:0] hit_note;
   logic [2:0] hit_length;
   logic       undo;
   logic       stop;

   modport master (
      output hit_valid, hit_octave, hit_note, hit_length, undo, stop
   );

   modport slave (
      input  hit_valid, hit_octave, hit_note, hit_length, undo, stop
   );
endinterface

// File: rtl/record_mode.sv
// Song capture engine: stores key hits as {octave,note,length} track entries, writes same edge, reads one cycle later.
// Always accepts input (no backpressure); RECORD_REST_EN adds automatic rest insertion during idle beat gaps.
module record_mode #(
   parameter int         DEPTH       = 64,
   parameter int         REST_TICKS  = 8,
   parameter logic [2:0] REST_OCTAVE = 3'b100,
   localparam int        AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          beat_tick,
   record_mode_if.slave  hit_if,
   input  logic [AW-1:0] rd_addr,
   output logic [2:0]    rd_octave,
   output logic [2:0]    rd_note,
   output logic [2:0]    rd_length,
   output logic [AW:0]   track,
   output logic [1:0]    state,
   output logic          full
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ARMED  = 2'b01,
      S_RECORD = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   localparam logic [AW:0] ONE_T   = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_T = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_T  = DEPTH_T - ONE_T;

   state_t      cur_st;
   state_t      nxt_st;
   logic [8:0]  mem [DEPTH];
   logic [8:0]  rd_q;
   logic [AW:0] track_q;
   logic [AW:0] track_nxt;
   logic        wr_en;
   logic [8:0]  wr_dat;
   logic        gap_clr;
   logic        hit_ok;
   logic        at_last;
   logic        rest_fire;
   logic [8:0]  rest_dat;

   // Note 0 is reserved for rests, so such a hit carries no information.
   assign hit_ok   = hit_if.hit_valid && (hit_if.hit_note != 3'd0);
   assign at_last  = (track_q == LAST_T);
   assign rest_dat = {REST_OCTAVE, 3'd0, 3'd1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_st <= S_IDLE;
      else     cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st = cur_st;
      if (!en) begin
         nxt_st = S_IDLE;
      end else begin
         case (cur_st)
            S_IDLE:   nxt_st = S_ARMED;
            S_ARMED: begin
               if (hit_if.stop)  nxt_st = S_DONE;
               else if (hit_ok)  nxt_st = S_RECORD;
            end
            S_RECORD: begin
               if (hit_if.stop || ((hit_ok || rest_fire) && at_last))
                  nxt_st = S_DONE;
            end
            default:  nxt_st = cur_st;
         endcase
      end
   end

   // A hit outranks rest and undo; stop only drops the lower-priority events.
   always_comb begin
      wr_en     = 1'b0;
      wr_dat    = {hit_if.hit_octave, hit_if.hit_note, hit_if.hit_length};
      track_nxt = track_q;
      gap_clr   = 1'b0;
      if (en) begin
         case (cur_st)
            S_IDLE: track_nxt = '0;
            S_ARMED, S_RECORD: begin
               if (hit_ok) begin
                  wr_en     = 1'b1;
                  track_nxt = track_q + ONE_T;
                  gap_clr   = 1'b1;
               end else if (rest_fire) begin
                  wr_en     = 1'b1;
                  wr_dat    = rest_dat;
                  track_nxt = track_q + ONE_T;
                  gap_clr   = 1'b1;
               end else if (!hit_if.stop && (cur_st == S_RECORD) &&
                            hit_if.undo && (track_q != '0)) begin
                  track_nxt = track_q - ONE_T;
                  gap_clr   = 1'b1;
               end
            end
            default: track_nxt = track_q;
         endcase
      end
   end

`ifdef RECORD_REST_EN
   localparam logic [7:0] REST_THR = 8'(REST_TICKS - 1);

   logic [7:0] gap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gap_q <= '0;
      else if (gap_clr)
         gap_q <= '0;
      else if (en && (cur_st == S_RECORD) && beat_tick && (gap_q != 8'hFF))
         gap_q <= gap_q + 8'd1;
   end

   // The tick that would bring the gap up to REST_TICKS emits the rest instead.
   assign rest_fire = en && (cur_st == S_RECORD) && beat_tick && !hit_if.stop &&
                      !hit_ok && (gap_q >= REST_THR);
`else
   logic unused_rest;

   assign rest_fire   = 1'b0;
   assign unused_rest = ^{REST_TICKS, gap_clr, beat_tick};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) track_q <= '0;
      else     track_q <= track_nxt;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[track_q[AW-1:0]] <= wr_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= mem[rd_addr];
   end

   assign rd_octave = rd_q[8:6];
   assign rd_note   = rd_q[5:3];
   assign rd_length = rd_q[2:0];
   assign track     = track_q;
   assign state     = cur_st;
   assign full      = (track_q == DEPTH_T);

endmodule

// File: tb/tb_record_mode.sv
// Bench for record_mode: a 64-entry and a 4-entry instance driven through scripted takes.
// Rest expectations follow RECORD_REST_EN as defined for the build.
module tb_record_mode;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       en_a = 1'b0;
   logic       en_b = 1'b0;
   logic       tick = 1'b0;
   logic [5:0] rd_addr_a = '0;
   logic [1:0] rd_addr_b = '0;
   logic [2:0] oct_a, note_a, len_a, oct_b, note_b, len_b;
   logic [6:0] track_a;
   logic [2:0] track_b;
   logic [1:0] state_a, state_b;
   logic       full_a, full_b;

   record_mode_if ia();
   record_mode_if ib();

   record_mode #(.DEPTH(64)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .beat_tick(tick), .hit_if(ia),
      .rd_addr(rd_addr_a), .rd_octave(oct_a), .rd_note(note_a), .rd_length(len_a),
      .track(track_a), .state(state_a), .full(full_a)
   );

   record_mode #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .beat_tick(tick), .hit_if(ib),
      .rd_addr(rd_addr_b), .rd_octave(oct_b), .rd_note(note_b), .rd_length(len_b),
      .track(track_b), .state(state_b), .full(full_b)
   );

   int n_checks = 0;
   int n_errs   = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop(input logic [31:0] got);
      if (exp_q.size() == 0) begin
         n_errs++;
         $display("FAIL sb_underflow: got %0d with nothing expected", got);
      end else begin
         check(tag_q.pop_front(), got, exp_q.pop_front());
      end
   endtask

   function automatic logic [8:0] ent(input logic [2:0] o, input logic [2:0] n, input logic [2:0] l);
      return {o, n, l};
   endfunction

   task automatic hit(input bit sel, input logic [2:0] o, input logic [2:0] n,
                      input logic [2:0] l, input bit stp);
      if (sel) begin
         ib.hit_valid = 1'b1; ib.hit_octave = o; ib.hit_note = n; ib.hit_length = l; ib.stop = stp;
      end else begin
         ia.hit_valid = 1'b1; ia.hit_octave = o; ia.hit_note = n; ia.hit_length = l; ia.stop = stp;
      end
      @(negedge clk);
      ia.hit_valid = 1'b0; ia.stop = 1'b0;
      ib.hit_valid = 1'b0; ib.stop = 1'b0;
   endtask

   task automatic undo_a();
      ia.undo = 1'b1;
      @(negedge clk);
      ia.undo = 1'b0;
   endtask

   task automatic stop_a();
      ia.stop = 1'b1;
      @(negedge clk);
      ia.stop = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic read_a(input string tag, input logic [5:0] addr, input logic [8:0] exp);
      rd_addr_a = addr;
      sb_push(tag, exp);
      @(negedge clk);
      sb_pop({oct_a, note_a, len_a});
   endtask

   task automatic read_b(input string tag, input logic [1:0] addr, input logic [8:0] exp);
      rd_addr_b = addr;
      sb_push(tag, exp);
      @(negedge clk);
      sb_pop({oct_b, note_b, len_b});
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] exp_tr;
      ia.hit_valid = 0; ia.hit_octave = 0; ia.hit_note = 0; ia.hit_length = 0; ia.undo = 0; ia.stop = 0;
      ib.hit_valid = 0; ib.hit_octave = 0; ib.hit_note = 0; ib.hit_length = 0; ib.undo = 0; ib.stop = 0;
      repeat (2) @(negedge clk);

      check("rst_state_a", state_a, 0);
      check("rst_track_a", track_a, 0);
      check("rst_full_a",  full_a,  0);
      check("rst_rd_a",    {oct_a, note_a, len_a}, 0);
      check("rst_full_b",  full_b,  0);
      rst = 1'b0;

      // ARMED ignores ticks, then stop ends an empty take
      en_a = 1'b1;
      @(negedge clk);
      check("armed_state", state_a, 1);
      ticks(20);
      check("armed_ticks_track", track_a, 0);
      check("armed_ticks_state", state_a, 1);
      stop_a();
      check("armed_stop_state", state_a, 3);
      check("armed_stop_track", track_a, 0);
      en_a = 1'b0;
      @(negedge clk);
      check("leave_idle", state_a, 0);
      en_a = 1'b1;
      @(negedge clk);

      // basic take and readback
      hit(0, 3'd4, 3'd1, 3'd2, 0);
      check("first_hit_state", state_a, 2);
      hit(0, 3'd4, 3'd3, 3'd2, 0);
      hit(0, 3'd5, 3'd5, 3'd1, 0);
      check("take_track", track_a, 3);
      check("take_state", state_a, 2);
      read_a("rd0", 6'd0, ent(4, 1, 2));
      read_a("rd1", 6'd1, ent(4, 3, 2));
      read_a("rd2", 6'd2, ent(5, 5, 1));

      // undo twice, overwrite entry 1 while reading it
      undo_a();
      undo_a();
      check("undo2_track", track_a, 1);
      rd_addr_a = 6'd1;
      sb_push("rbw_old", ent(4, 3, 2));
      hit(0, 3'd2, 3'd7, 3'd3, 0);
      sb_pop({oct_a, note_a, len_a});
      check("rewrite_track", track_a, 2);
      read_a("rbw_new", 6'd1, ent(2, 7, 3));

      undo_a();
      undo_a();
      undo_a();
      check("undo_floor", track_a, 0);
      check("undo_floor_state", state_a, 2);
      hit(0, 3'd3, 3'd0, 3'd2, 0);
      check("note0_ignored", track_a, 0);

      // idle gap after a hit
      hit(0, 3'd4, 3'd1, 3'd2, 0);
      ticks(17);
`ifdef RECORD_REST_EN
      check("rest_track", track_a, 3);
      read_a("rest1", 6'd1, ent(4, 0, 1));
      read_a("rest2", 6'd2, ent(4, 0, 1));
      exp_tr = 7'd4;
`else
      check("norest_track", track_a, 1);
      exp_tr = 7'd2;
`endif

      // hit and stop on one edge: hit lands, then DONE
      hit(0, 3'd1, 3'd2, 3'd3, 1);
      check("hitstop_track", track_a, exp_tr);
      check("hitstop_state", state_a, 3);
      hit(0, 3'd6, 3'd6, 3'd6, 0);
      undo_a();
      check("done_hold_track", track_a, exp_tr);
      en_a = 1'b0;
      @(negedge clk);
      check("a_idle_state", state_a, 0);
      check("a_idle_track", track_a, exp_tr);
      read_a("a_idle_rd", 6'(exp_tr - 7'd1), ent(1, 2, 3));

      // small buffer fills and closes the take
      en_b = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         hit(1, 3'(i), 3'(i), 3'(i), 0);
         if (i < 4) check("b_fill_state", state_b, 2);
      end
      check("b_full_track", track_b, 4);
      check("b_full_flag", full_b, 1);
      check("b_full_state", state_b, 3);
      hit(1, 3'd5, 3'd5, 3'd5, 0);
      check("b_extra_track", track_b, 4);
      read_b("b_entry0_kept", 2'd0, ent(1, 1, 1));
      en_b = 1'b0;
      @(negedge clk);
      check("b_idle_state", state_b, 0);
      check("b_idle_track", track_b, 4);
      read_b("b_idle_rd3", 2'd3, ent(4, 4, 4));

      // asynchronous reset in the middle of a take
      en_b = 1'b1;
      @(negedge clk);
      check("b_rearm_track", track_b, 0);
      hit(1, 3'd6, 3'd1, 3'd1, 0);
      hit(1, 3'd6, 3'd2, 3'd2, 0);
      check("b_mid_track", track_b, 2);
      read_b("b_mid_rd0", 2'd0, ent(6, 1, 1));
      #2 rst = 1'b1;
      #1;
      check("arst_state", state_b, 0);
      check("arst_track", track_b, 0);
      check("arst_full",  full_b,  0);
      check("arst_rd",    {oct_b, note_b, len_b}, 0);
      @(negedge clk);
      rst = 1'b0;
      en_b = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
